// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT address-generation unit:
// FSM state encoding, geometry helpers and the write-back record carried
// through the read-to-write delay line.
package fft_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } fft_agu_state_t;

    // Widest address the write-back record can carry (N_LOG2 must not exceed it)
    localparam int unsigned FFT_ADDR_W_MAX = 16;

    // Transform size N
    function automatic int unsigned fft_n(input int unsigned n_log2);
        return 32'd1 << n_log2;
    endfunction

    // Butterflies per stage, N/2
    function automatic int unsigned fft_half(input int unsigned n_log2);
        return 32'd1 << (n_log2 - 32'd1);
    endfunction

    // Stage-counter width, clog2(N_LOG2) but never below one bit
    function automatic int unsigned fft_stage_w(input int unsigned n_log2);
        return (n_log2 <= 32'd2) ? 32'd1 : 32'($clog2(n_log2));
    endfunction

    // One write-back slot: strobe plus the operand-pair destination
    typedef struct packed {
        logic                      valid;
        logic [FFT_ADDR_W_MAX-1:0] addr0;
        logic [FFT_ADDR_W_MAX-1:0] addr1;
    } fft_wb_rec_t;

endpackage

// File: rtl/fft_agu_delay.sv
// DEPTH-stage shift register carrying {valid, addr0, addr1} from the read
// issue point to the write-back point. DEPTH=0 is a pure pass-through.
// Ports:
//   clk_i                       clock
//   clr_i                       synchronous clear of every slot
//   in_valid_i/in_addr0_i/1_i   record entering the line
//   out_valid_o/out_addr0_o/1_o record leaving the line DEPTH cycles later
module fft_agu_delay
    import fft_pkg::*;
#(
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              in_valid_i,
    input  logic [ADDR_W-1:0] in_addr0_i,
    input  logic [ADDR_W-1:0] in_addr1_i,
    output logic              out_valid_o,
    output logic [ADDR_W-1:0] out_addr0_o,
    output logic [ADDR_W-1:0] out_addr1_o
);

    if (DEPTH == 0) begin : g_pass
        assign out_valid_o = in_valid_i;
        assign out_addr0_o = in_addr0_i;
        assign out_addr1_o = in_addr1_i;

        // Clock and clear have no job without storage
        logic unused_ctl;
        assign unused_ctl = clk_i ^ clr_i;
    end else begin : g_pipe
        fft_wb_rec_t pipe_q [DEPTH];

        // Shift one slot per cycle; clear drops everything in flight
        always_ff @(posedge clk_i) begin
            if (clr_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0].valid <= in_valid_i;
                pipe_q[0].addr0 <= FFT_ADDR_W_MAX'(in_addr0_i);
                pipe_q[0].addr1 <= FFT_ADDR_W_MAX'(in_addr1_i);
                for (int i = 1; i < DEPTH; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign out_valid_o = pipe_q[DEPTH-1].valid;
        assign out_addr0_o = pipe_q[DEPTH-1].addr0[ADDR_W-1:0];
        assign out_addr1_o = pipe_q[DEPTH-1].addr1[ADDR_W-1:0];

        // Upper address bits of the record are always zero here
        logic unused_hi;
        assign unused_hi = ^pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/fft_agu_ctrl.sv
// Control/address generator for an in-place radix-2 DIT FFT driving a shared
// butterfly. Walks N_LOG2 stages of N/2 butterflies, issues operand read
// addresses plus twiddle index, and re-issues the same addresses as write-back
// D = RD_LATENCY + BF_LATENCY cycles later. A D-cycle gap between stages keeps
// every read of stage s+1 behind the final write of stage s.
// Optional feature macro: FFT_AGU_INV_EN adds inverse (in) and tw_conj (out).
// Ports:
//   clk, rst (sync, active high), start
//   busy, done                    run status / completion pulse
//   rd_en, rd_addr0/1, tw_addr    operand read and twiddle index
//   wr_en, wr_addr0/1             delayed write-back
//   stage                         current stage (status only)
module fft_agu_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned N_LOG2     = 5,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BF_LATENCY = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
`ifdef FFT_AGU_INV_EN
    input  logic                             inverse,
`endif
    output logic                             busy,
    output logic                             done,
    output logic                             rd_en,
    output logic [N_LOG2-1:0]                rd_addr0,
    output logic [N_LOG2-1:0]                rd_addr1,
    output logic [N_LOG2-2:0]                tw_addr,
`ifdef FFT_AGU_INV_EN
    output logic                             tw_conj,
`endif
    output logic                             wr_en,
    output logic [N_LOG2-1:0]                wr_addr0,
    output logic [N_LOG2-1:0]                wr_addr1,
    output logic [fft_stage_w(N_LOG2)-1:0]   stage
);

    localparam int unsigned D    = RD_LATENCY + BF_LATENCY;
    localparam int unsigned HALF = fft_half(N_LOG2);
    localparam int unsigned SW   = fft_stage_w(N_LOG2);
    localparam int unsigned KW   = N_LOG2 - 1;
    localparam int unsigned TW   = N_LOG2 - 1;
    localparam int unsigned GW   = (D <= 1) ? 1 : $clog2(D);

    fft_agu_state_t  state_q;
    logic [SW-1:0]   s_q, s_d;
    logic [KW-1:0]   k_q, k_d;
    logic [GW-1:0]   gap_q;
    logic            busy_q, done_q, rd_en_q;
    logic [N_LOG2-1:0] rd_addr0_q, rd_addr1_q;
    logic [TW-1:0]   tw_q;
    logic            k_last_c, s_last_c, issue_c;
`ifdef FFT_AGU_INV_EN
    logic            inv_q, tw_conj_q;
`endif

    // x0 address: insert a zero at bit s of k, i.e. (k>>s)<<(s+1) | (k & (half-1))
    function automatic logic [N_LOG2-1:0] addr0_f(input logic [SW-1:0] s, input logic [KW-1:0] k);
        logic [N_LOG2-1:0] kk, mask;
        kk   = N_LOG2'(k);
        mask = (N_LOG2'(1) << s) - N_LOG2'(1);
        return ((kk & ~mask) << 1) | (kk & mask);
    endfunction

    // Twiddle index: j scaled so every stage indexes the same N/2-entry ROM
    function automatic logic [TW-1:0] tw_f(input logic [SW-1:0] s, input logic [KW-1:0] k);
        logic [N_LOG2-1:0] kk, mask;
        kk   = N_LOG2'(k);
        mask = (N_LOG2'(1) << s) - N_LOG2'(1);
        return TW'((kk & mask) << (N_LOG2 - 1 - 32'(s)));
    endfunction

    // Decide whether a butterfly read goes out on the next edge, and which one
    always_comb begin
        k_last_c = (k_q == KW'(HALF - 1));
        s_last_c = (s_q == SW'(N_LOG2 - 1));
        s_d      = s_q + SW'(1);
        k_d      = '0;
        issue_c  = 1'b0;
        if (state_q == IDLE) begin
            s_d = '0;
        end else if (state_q == RUN && !k_last_c) begin
            s_d = s_q;
            k_d = k_q + KW'(1);
        end
        case (state_q)
            IDLE:    issue_c = start;
            RUN:     issue_c = !k_last_c || (D == 0 && !s_last_c);
            GAP:     issue_c = (gap_q == '0) && !s_last_c;
            default: issue_c = 1'b0;
        endcase
    end

    // Sequencer with registered read-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s_q        <= '0;
            k_q        <= '0;
            gap_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr0_q <= '0;
            rd_addr1_q <= '0;
            tw_q       <= '0;
`ifdef FFT_AGU_INV_EN
            inv_q      <= 1'b0;
            tw_conj_q  <= 1'b0;
`endif
        end else begin
            rd_en_q <= issue_c;
            done_q  <= 1'b0;
            if (issue_c) begin
                s_q        <= s_d;
                k_q        <= k_d;
                rd_addr0_q <= addr0_f(s_d, k_d);
                rd_addr1_q <= addr0_f(s_d, k_d) | (N_LOG2'(1) << s_d);
                tw_q       <= tw_f(s_d, k_d);
            end else begin
                rd_addr0_q <= '0;
                rd_addr1_q <= '0;
                tw_q       <= '0;
            end
`ifdef FFT_AGU_INV_EN
            // First read of a run uses the live input, later reads the latched copy
            tw_conj_q <= issue_c & ((state_q == IDLE) ? inverse : inv_q);
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
`ifdef FFT_AGU_INV_EN
                        inv_q   <= inverse;
`endif
                    end
                end
                RUN: begin
                    if (k_last_c) begin
                        if (D != 0) begin
                            state_q <= GAP;
                            gap_q   <= GW'(D - 1);
                        end else if (s_last_c) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
                        if (s_last_c) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    s_q     <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write-back follows the read strobe by the memory + butterfly depth
    fft_agu_delay #(
        .DEPTH  (D),
        .ADDR_W (N_LOG2)
    ) u_delay (
        .clk_i       (clk),
        .clr_i       (rst),
        .in_valid_i  (rd_en_q),
        .in_addr0_i  (rd_addr0_q),
        .in_addr1_i  (rd_addr1_q),
        .out_valid_o (wr_en),
        .out_addr0_o (wr_addr0),
        .out_addr1_o (wr_addr1)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_en    = rd_en_q;
    assign rd_addr0 = rd_addr0_q;
    assign rd_addr1 = rd_addr1_q;
    assign tw_addr  = tw_q;
    assign stage    = s_q;
`ifdef FFT_AGU_INV_EN
    assign tw_conj  = tw_conj_q;
`endif

endmodule

// File: tb/tb_fft_agu_ctrl.sv
// Scoreboard bench for fft_agu_ctrl with N_LOG2=3: one instance with D=1,
// one with D=0. Stimulus pushes hand-computed expected reads/writes/done
// into queues; negedge monitors pop and compare whenever the DUT strobes.
module tb_fft_agu_ctrl;

    localparam int BIG = 32'h3FFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start_z;
    logic       busy, done, rd_en, wr_en;
    logic [2:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic [1:0] tw_addr, stage;
    logic       busy_z, done_z, rd_en_z, wr_en_z;
    logic [2:0] rd_addr0_z, rd_addr1_z, wr_addr0_z, wr_addr1_z;
    logic [1:0] tw_addr_z, stage_z;
`ifdef FFT_AGU_INV_EN
    logic       inverse, tw_conj, inverse_z, tw_conj_z;
`endif

    fft_agu_ctrl #(.N_LOG2(3), .RD_LATENCY(1), .BF_LATENCY(0)) u_dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef FFT_AGU_INV_EN
        .inverse(inverse), .tw_conj(tw_conj),
`endif
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .tw_addr(tw_addr),
        .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .stage(stage)
    );

    fft_agu_ctrl #(.N_LOG2(3), .RD_LATENCY(0), .BF_LATENCY(0)) u_dut_z (
        .clk(clk), .rst(rst), .start(start_z),
`ifdef FFT_AGU_INV_EN
        .inverse(inverse_z), .tw_conj(tw_conj_z),
`endif
        .busy(busy_z), .done(done_z), .rd_en(rd_en_z),
        .rd_addr0(rd_addr0_z), .rd_addr1(rd_addr1_z), .tw_addr(tw_addr_z),
        .wr_en(wr_en_z), .wr_addr0(wr_addr0_z), .wr_addr1(wr_addr1_z), .stage(stage_z)
    );

    typedef struct {
        int cyc;
        int a0;
        int a1;
        int tw;
        int st;
        int cj;
    } exp_t;

    // Hand-computed butterfly order for N=8: stage 0, 1, 2 with k = 0..3
    int tab_a0 [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int tab_a1 [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int tab_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    exp_t rd_q[$], wr_q[$], rd_z_q[$];
    int   done_q[$], done_z_q[$];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected traffic for one transform started in cycle c0; entries at or
    // after cycle 'cut' are never pushed (reset drops them)
    task automatic push_run(input int c0, input int d, input bit to_z, input int cut, input int cj);
        exp_t e;
        int   s, k, rc, dc;
        for (int i = 0; i < 12; i++) begin
            s  = i / 4;
            k  = i % 4;
            rc = c0 + 1 + s * (4 + d) + k;
            e  = '{rc, tab_a0[i], tab_a1[i], tab_tw[i], s, cj};
            if (rc < cut) begin
                if (to_z) rd_z_q.push_back(e);
                else      rd_q.push_back(e);
            end
            e.cyc = rc + d;
            if (!to_z && e.cyc < cut) wr_q.push_back(e);
        end
        dc = c0 + 3 * (4 + d) + 1;
        if (dc < cut) begin
            if (to_z) done_z_q.push_back(dc);
            else      done_q.push_back(dc);
        end
    endtask

    // Monitor for the D=1 instance
    always @(negedge clk) begin : mon_main
        exp_t e;
        if (mon_en) begin
            if (rd_en) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    e = rd_q.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_addr0", int'(rd_addr0), e.a0);
                    chk("rd_addr1", int'(rd_addr1), e.a1);
                    chk("tw_addr", int'(tw_addr), e.tw);
                    chk("stage", int'(stage), e.st);
`ifdef FFT_AGU_INV_EN
                    chk("tw_conj", int'(tw_conj), e.cj);
`endif
                end
            end else begin
                chk("rd_idle_zero", int'({rd_addr0, rd_addr1, tw_addr}), 0);
`ifdef FFT_AGU_INV_EN
                chk("tw_conj_idle", int'(tw_conj), 0);
`endif
            end
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr0", int'(wr_addr0), e.a0);
                    chk("wr_addr1", int'(wr_addr1), e.a1);
                end
            end else begin
                chk("wr_idle_zero", int'({wr_addr0, wr_addr1}), 0);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                    chk("busy_at_done", int'(busy), 1);
                end
            end
        end
    end

    // Monitor for the D=0 instance: write-back must coincide with the read
    always @(negedge clk) begin : mon_z
        exp_t e;
        if (mon_en) begin
            if (rd_en_z) begin
                if (rd_z_q.size() == 0) begin
                    chk("z_rd_unexpected", 1, 0);
                end else begin
                    e = rd_z_q.pop_front();
                    chk("z_rd_cycle", cyc, e.cyc);
                    chk("z_rd_addr0", int'(rd_addr0_z), e.a0);
                    chk("z_rd_addr1", int'(rd_addr1_z), e.a1);
                    chk("z_tw_addr", int'(tw_addr_z), e.tw);
                    chk("z_wr_en", int'(wr_en_z), 1);
                    chk("z_wr_addr0", int'(wr_addr0_z), e.a0);
                    chk("z_wr_addr1", int'(wr_addr1_z), e.a1);
                end
            end else begin
                chk("z_wr_idle", int'(wr_en_z), 0);
            end
            if (done_z) begin
                if (done_z_q.size() == 0) chk("z_done_unexpected", 1, 0);
                else                      chk("z_done_cycle", cyc, done_z_q.pop_front());
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rd_q.size() + wr_q.size() + done_q.size() + rd_z_q.size() + done_z_q.size()) != 0
               && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("queue_left", rd_q.size() + wr_q.size() + done_q.size() + rd_z_q.size() + done_z_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int c0;
        rst     = 1'b1;
        start   = 1'b0;
        start_z = 1'b0;
`ifdef FFT_AGU_INV_EN
        inverse   = 1'b0;
        inverse_z = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_addrs", int'({rd_addr0, rd_addr1, tw_addr, wr_addr0, wr_addr1}), 0);
        chk("rst_stage", int'(stage), 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Forward run on both instances
        c0 = cyc;
        chk("idle_busy", int'(busy), 0);
        start   = 1'b1;
        start_z = 1'b1;
        push_run(c0, 1, 1'b0, BIG, 0);
        push_run(c0, 0, 1'b1, BIG, 0);
        @(posedge clk);
        #1;
        chk("busy_cycle1", int'(busy), 1);
        chk("z_busy_cycle1", int'(busy_z), 1);
        start   = 1'b0;
        start_z = 1'b0;
        drain();

        // Reset during stage 1: writes still in flight are dropped
        c0    = cyc;
        start = 1'b1;
        push_run(c0, 1, 1'b0, c0 + 9, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_until(c0 + 8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_rd_en", int'(rd_en), 0);
        chk("midrst_wr_en", int'(wr_en), 0);
        chk("midrst_addrs", int'({rd_addr0, rd_addr1, tw_addr, wr_addr0, wr_addr1}), 0);
        chk("midrst_stage", int'(stage), 0);
        drain();

        // Fresh transform after the reset starts again from stage 0
        c0    = cyc;
        start = 1'b1;
        push_run(c0, 1, 1'b0, BIG, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // Start held high: second run accepted only in the IDLE cycle after done
        c0    = cyc;
        start = 1'b1;
        push_run(c0, 1, 1'b0, BIG, 0);
        push_run(c0 + 17, 1, 1'b0, BIG, 0);
        wait_until(c0 + 20);
        start = 1'b0;
        drain();

`ifdef FFT_AGU_INV_EN
        // Inverse latched at start; dropping the input later must not matter
        c0      = cyc;
        start   = 1'b1;
        inverse = 1'b1;
        push_run(c0, 1, 1'b0, BIG, 1);
        @(posedge clk);
        #1;
        start   = 1'b0;
        inverse = 1'b0;
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_agu_ctrl.md
# fft_agu_ctrl

Control and address-generation stage that sits directly upstream of the shared combinational butterfly in the in-place radix-2 DIT FFT. It sequences all stages and butterflies of one transform. Per butterfly it issues data-memory read addresses for the operand pair and a twiddle ROM index, and it issues matching write-back addresses delayed by the memory/butterfly pipeline depth. It also inserts hazard gaps between stages so that no read overtakes a pending write.

## Interface
Parameters:
- N_LOG2, 5, log2 of transform size N (N = 2^N_LOG2, N/2 butterflies per stage)
- RD_LATENCY, 1, data-memory read latency in cycles
- BF_LATENCY, 0, butterfly pipeline depth (0 for the combinational butterfly)

Ports (D = RD_LATENCY + BF_LATENCY):
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin transform; sampled in IDLE only
- busy  out  1  high from the cycle after start is accepted through the done cycle, inclusive
- done  out  1  one-cycle pulse when the final write-back has been issued
- rd_en  out  1  operand read strobe
- rd_addr0  out  N_LOG2  address of x0
- rd_addr1  out  N_LOG2  address of x1
- tw_addr  out  N_LOG2-1  twiddle ROM index, valid with rd_en
- wr_en  out  1  write-back strobe, exactly D cycles after the matching rd_en
- wr_addr0  out  N_LOG2  destination of out_x0
- wr_addr1  out  N_LOG2  destination of out_x1
- stage  out  clog2(N_LOG2)  current stage index, debug/status only

## Operation
- FSM states: IDLE, RUN, GAP, DONE.
- IDLE: start=1 sets stage s=0, k=0, and moves to RUN.
- RUN: rd_en=1 every cycle. Addresses are computed as follows:
  - half = 1<<s, grp = k>>s, j = k & (half-1)
  - rd_addr0 = (grp<<(s+1)) | j
  - rd_addr1 = rd_addr0 + half
  - tw_addr = j << (N_LOG2-1-s)
- k increments each cycle. At k = N/2-1 the FSM goes to GAP.
- GAP: rd_en=0 for exactly D cycles while the write pipeline drains.
  - If s < N_LOG2-1: s++, k=0, and return to RUN.
  - Otherwise go to DONE.
- If D=0, GAP is skipped entirely.
- DONE: done=1 for one cycle, then IDLE.
- Write-back path: a D-deep shift register carries {valid, addr0, addr1}. wr_en and wr_addr0/1 are its output. When D=0, the write-back outputs are wired directly to the read outputs.
- Data memory is assumed to be bit-reversed-loaded. Output appears in natural order.
- start while busy: ignored.
- rst mid-operation: the next edge forces IDLE and all outputs to 0, and the shift register is cleared. In-flight writes are dropped, not completed.
- Reset values: busy, done, rd_en, wr_en, all addresses, tw_addr and stage are 0.
- rd_addr*/tw_addr hold 0 whenever rd_en=0. wr_addr* hold 0 whenever wr_en=0.

## Timing
- start accepted at cycle 0; first rd_en at cycle 1.
- Total latency: done asserts at cycle N_LOG2*(N/2 + D) + 1. For example, N_LOG2=3, D=1 gives 16.
- Last write-back occurs at cycle N_LOG2*(N/2 + D).
- Stage s+1 never reads before the final write of stage s has been issued. The memory must return the written value on a read issued one cycle later.
- A new start is accepted in the cycle after done (IDLE), giving back-to-back transforms with one idle cycle between them.

## Configuration
- FFT_AGU_INV_EN defined:
  - adds input inverse (1 bit), sampled together with start and held for the whole run
  - adds output tw_conj (1 bit), equal to the latched inverse whenever rd_en=1 and 0 otherwise
  - the twiddle ROM wrapper negates the imaginary part when tw_conj=1, producing an inverse transform (unscaled)
- Undefined: neither port exists, and behaviour is forward FFT only.

## Structure
- Shared package fft_pkg contains:
  - the FSM state enum fft_agu_state_t (IDLE/RUN/GAP/DONE)
  - the localparam helpers for N, N/2 and stage-counter width
  - the write-back record type {valid, addr0, addr1}
- One sub-module, fft_agu_delay: a parameterised D-deep valid/address shift register with synchronous clear. It must handle D=0 as a pass-through.

## Test plan
- N_LOG2=3, D=1, pulse start at cycle 0:
  - stage 0 reads (0,1),(2,3),(4,5),(6,7), all with tw 0
  - GAP at cycle 5
  - done at cycle 16
- Same configuration, stage 1, k=3: rd_addr0=5, rd_addr1=7, tw_addr=2. Stage 2, k=1: rd_addr0=1, rd_addr1=5, tw_addr=1.
- Write-back check: every wr_en pulse equals the rd_en pulse 1 cycle earlier with identical addresses. Exactly 12 write pulses per transform.
- Assert rst at cycle 8 (mid stage 1):
  - from cycle 9 all outputs are 0 and no wr_en follows
  - a subsequent start produces the full 16-cycle sequence from stage 0
- start held high continuously:
  - first transform completes at cycle 16
  - next rd_en appears at cycle 18; no start is accepted while busy
- With FFT_AGU_INV_EN defined, inverse=1 at start: tw_conj=1 on all 12 read cycles, with addresses identical to the forward run. With D=0 (RD_LATENCY=0): no GAP states, and done occurs at cycle 13.
